// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scan + debounce; in clk/rst(async low)/scan_en/enable/keypadCol, out keypadRow/key_valid/key_row/key_col/key_held
module keypad_scanner #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int RELEASE_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       enable,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic       key_valid,
  output logic [1:0] key_row,
  output logic [1:0] key_col,
  output logic       key_held
);
  typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HELD} state_t;
  localparam logic [3:0] DB = 4'(DEBOUNCE_TICKS);
  localparam logic [3:0] RL = 4'(RELEASE_TICKS);
  state_t state, state_n;
  logic [3:0] col_m, col_s, cnt, cnt_n, row_drv_n;
  logic [1:0] row_idx, row_n, cap_col, cap_n, key_row_n, key_col_n, col_idx;
  logic held_n, valid_n, one_low;
  assign one_low = $onehot(~col_s);
  assign col_idx = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
  always_comb begin
    state_n   = state;
    row_n     = row_idx;
    cnt_n     = cnt;
    cap_n     = cap_col;
    key_row_n = key_row;
    key_col_n = key_col;
    held_n    = key_held;
    valid_n   = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      row_n   = 2'd0;
      cnt_n   = 4'd0;
      held_n  = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = SCAN;
        SCAN: if (scan_en) begin
          if (one_low) begin
            state_n = DEBOUNCE;
            cnt_n   = 4'd1;
            cap_n   = col_idx;
          end else row_n = row_idx + 2'd1;
        end
        DEBOUNCE: if (scan_en) begin
          if (col_s == ~(4'b0001 << cap_col)) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n == DB) begin
              state_n   = HELD;
              cnt_n     = 4'd0;
              valid_n   = 1'b1;
              held_n    = 1'b1;
              key_row_n = row_idx;
              key_col_n = cap_col;
            end
          end else begin
            state_n = SCAN;
            cnt_n   = 4'd0;
            row_n   = row_idx + 2'd1;
          end
        end
        HELD: if (scan_en) begin
          if (col_s == 4'b1111) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n == RL) begin
              state_n = SCAN;
              cnt_n   = 4'd0;
              held_n  = 1'b0;
              row_n   = row_idx + 2'd1;
            end
          end else cnt_n = 4'd0;
        end
      endcase
    end
    row_drv_n = state_n == IDLE ? 4'b0000 : ~(4'b0001 << row_n);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_m     <= 4'b1111;
      col_s     <= 4'b1111;
      state     <= IDLE;
      row_idx   <= 2'd0;
      cnt       <= 4'd0;
      cap_col   <= 2'd0;
      keypadRow <= 4'b0000;
      key_valid <= 1'b0;
      key_row   <= 2'd0;
      key_col   <= 2'd0;
      key_held  <= 1'b0;
    end else begin
      col_m     <= keypadCol;
      col_s     <= col_m;
      state     <= state_n;
      row_idx   <= row_n;
      cnt       <= cnt_n;
      cap_col   <= cap_n;
      keypadRow <= row_drv_n;
      key_valid <= valid_n;
      key_row   <= key_row_n;
      key_col   <= key_col_n;
      key_held  <= held_n;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scoreboard bench for keypad_scanner
module tb_keypad_scanner;
  logic clk = 0, rst = 0, scan_en = 0, enable = 0;
  logic [3:0] keypadCol, keypadRow;
  logic key_valid, key_held;
  logic [1:0] key_row, key_col;
  logic key_on = 0, ovr = 0;
  logic [3:0] ovr_val = 4'hf, er, exp_key;
  logic [1:0] key_r = 2'd2, key_c = 2'd1;
  int vectors = 0, errors = 0, pulses = 0, exp_pulses = 0;
  logic [3:0] exp_q[$];
  always #5 clk = ~clk;
  keypad_scanner dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .enable(enable),
    .keypadCol(keypadCol), .keypadRow(keypadRow), .key_valid(key_valid),
    .key_row(key_row), .key_col(key_col), .key_held(key_held)
  );
  always_comb keypadCol = ovr ? ovr_val : (key_on && !keypadRow[key_r]) ? ~(4'b0001 << key_c) : 4'b1111;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    repeat (3) @(negedge clk);
    scan_en = 1;
    @(negedge clk);
    scan_en = 0;
  endtask
  task automatic expect_key(input logic [1:0] r, input logic [1:0] c);
    exp_q.push_back({r, c});
    exp_pulses++;
  endtask
  always @(negedge clk) begin
    if (key_valid) begin
      pulses++;
      vectors++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed key_valid=1 with row %0d col %0d, expected no pulse", key_row, key_col);
      end
      if (exp_q.size() != 0) begin
        exp_key = exp_q.pop_front();
        chk("pulse_key", {28'd0, key_row, key_col}, {28'd0, exp_key});
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_row", keypadRow, 4'b0000);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_key", {key_row, key_col}, 0);
    rst = 1;
    @(negedge clk);
    chk("idle_row", keypadRow, 4'b0000);
    enable = 1;
    @(negedge clk);
    chk("scan_start", keypadRow, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      tick();
      er = ~(4'b0001 << ((i + 1) % 4));
      chk("row_scan", keypadRow, er);
    end
    key_r = 2; key_c = 1; key_on = 1;
    expect_key(2, 1);
    tick();
    chk("press_row_active", keypadRow, 4'b1011);
    repeat (3) begin
      tick();
      chk("debounce_no_pulse", key_valid, 0);
    end
    tick();
    chk("press_valid", key_valid, 1);
    chk("press_key_row", key_row, 2);
    chk("press_key_col", key_col, 1);
    chk("press_held", key_held, 1);
    chk("press_row_frozen", keypadRow, 4'b1011);
    @(negedge clk);
    chk("valid_one_clk", key_valid, 0);
    repeat (20) tick();
    chk("hold_single_pulse", pulses, exp_pulses);
    chk("hold_held", key_held, 1);
    chk("hold_row_frozen", keypadRow, 4'b1011);
    key_on = 0;
    repeat (3) tick();
    chk("short_release_held", key_held, 1);
    key_on = 1;
    repeat (2) tick();
    chk("repress_no_pulse", pulses, exp_pulses);
    key_on = 0;
    repeat (3) tick();
    chk("release_cnt_restarted", key_held, 1);
    tick();
    chk("release_held", key_held, 0);
    chk("release_scan_resumes", keypadRow, 4'b0111);
    key_on = 1;
    repeat (3) tick();
    chk("bounce_row_active", keypadRow, 4'b1011);
    tick();
    key_on = 0;
    tick();
    chk("bounce_next_row", keypadRow, 4'b0111);
    key_on = 1;
    tick();
    chk("bounce_scan_wraps", keypadRow, 4'b1110);
    chk("bounce_no_pulse", pulses, exp_pulses);
    key_on = 0; ovr = 1; ovr_val = 4'b1001;
    tick();
    chk("chord_ignored", keypadRow, 4'b1101);
    tick();
    chk("chord_ignored2", keypadRow, 4'b1011);
    chk("chord_no_pulse", pulses, exp_pulses);
    ovr = 0; key_on = 1;
    tick();
    tick();
    chk("debounce_frozen", keypadRow, 4'b1011);
    enable = 0;
    @(negedge clk);
    chk("disable_row", keypadRow, 4'b0000);
    chk("disable_valid", key_valid, 0);
    chk("disable_held", key_held, 0);
    repeat (6) @(negedge clk);
    chk("disable_no_pulse", pulses, exp_pulses);
    chk("disable_key_kept", {key_row, key_col}, 4'b1001);
    key_r = 1; key_c = 3;
    expect_key(1, 3);
    enable = 1;
    @(negedge clk);
    chk("reenable_row", keypadRow, 4'b1110);
    repeat (4) tick();
    chk("second_no_early_pulse", key_valid, 0);
    tick();
    chk("second_valid", key_valid, 1);
    chk("second_key", {key_row, key_col}, 4'b0111);
    chk("second_held", key_held, 1);
    #2 rst = 0;
    #1;
    chk("async_rst_row", keypadRow, 4'b0000);
    chk("async_rst_valid", key_valid, 0);
    chk("async_rst_held", key_held, 0);
    chk("async_rst_key", {key_row, key_col}, 0);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("final_pulses", pulses, exp_pulses);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
